csi2_pkt_handler_mw: RTL and testbench

//  Parametrised CSI-2 packet handler; successor to the fixed 32-bit handler. Sits after lane merge + header ECC.

---
 rtl/csi2_pkg.sv | 13 +
 rtl/csi2_crc16_bytes.sv | 22 ++
 rtl/csi2_pkt_handler_mw.sv | 142 ++++++++++++++
 tb/tb_csi2_pkt_handler_mw.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// csi2_pkg: shared CSI-2 header layout, FSM states and CRC-16 constants.
package csi2_pkg;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  typedef struct packed {
    logic [1:0] vc;
    logic [5:0] dt;
    logic [15:0] wc;
    logic [7:0] ecc;
  } csi2_hdr_t;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DROP} state_t;
endpackage

// File: rtl/csi2_crc16_bytes.sv
// csi2_crc16_bytes: reflected CRC-16 update over up to BYTES byte-enabled bytes (present only with CSI2_PKT_CRC_EN).
`ifdef CSI2_PKT_CRC_EN
module csi2_crc16_bytes
  import csi2_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic [15:0]        crc_in,
  input  logic [8*BYTES-1:0] data,
  input  logic [BYTES-1:0]   be,
  output logic [15:0]        crc
);
  always_comb begin
    crc = crc_in;
    for (int b = 0; b < BYTES; b++)
      if (be[b]) begin
        crc = crc ^ {8'h00, data[8*b +: 8]};
        for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
      end
  end
endmodule
`endif

// File: rtl/csi2_pkt_handler_mw.sv
// csi2_pkt_handler_mw: CSI-2 header decode, short/long split, payload streaming with byte enables and VC filter.
// Define CSI2_PKT_CRC_EN to check the payload CRC-16; otherwise CRC bytes are only counted.
module csi2_pkt_handler_mw
  import csi2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [3:0] VC_MASK = 4'hF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                sync_i,
  input  logic                valid_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                error_i,
  input  logic                error_corrected_i,
  output logic                short_pkt_valid_o,
  output logic [1:0]          short_pkt_v_channel_o,
  output logic [5:0]          short_pkt_data_type_o,
  output logic [15:0]         short_pkt_data_field_o,
  output logic                long_pkt_header_valid_o,
  output logic [1:0]          long_pkt_v_channel_o,
  output logic [5:0]          long_pkt_data_type_o,
  output logic [15:0]         long_pkt_word_cnt_o,
  output logic [DATA_W-1:0]   long_pkt_payload_o,
  output logic                long_pkt_payload_valid_o,
  output logic [DATA_W/8-1:0] long_pkt_payload_be_o,
  output logic                long_pkt_payload_last_o,
  output logic                pkt_done_o,
  output logic                hdr_err_o,
  output logic                crc_err_o
);
  localparam int BYTES = DATA_W / 8;
  state_t state, st, nxt;
  csi2_hdr_t hdr;
  logic [16:0] rem, rem_in, rem_nx, avail, p, left, c, crc_in, crc_nx;
  logic [1:0] crc_left;
  logic [2:0] hoff;
  logic [DATA_W-1:0] pl;
  logic [BYTES-1:0] pbe;
  logic bad, hdr_go, short_go, long_hdr, long_go, fin, vc_ok, vc_en, pay_go, unused_ecc;
  assign unused_ecc = ^hdr.ecc;
  // Each word is split into payload bytes first, then CRC bytes; in IDLE only bytes above the header count.
  always_comb begin
    st = (sync_i && state != IDLE) ? IDLE : state;
    hdr = csi2_hdr_t'(data_i[31:0]);
    bad = error_i && !error_corrected_i;
    hdr_go = valid_i && st == IDLE;
    short_go = hdr_go && !bad && hdr.dt < DT_LONG_MIN;
    long_hdr = hdr_go && !bad && hdr.dt >= DT_LONG_MIN;
    long_go = long_hdr || (valid_i && (st == PAYLOAD || st == CRC));
    hoff = (st == IDLE) ? 3'd4 : 3'd0;
    avail = 17'(BYTES) - {14'd0, hoff};
    rem_in = (st == IDLE) ? {1'b0, hdr.wc} : (st == PAYLOAD) ? rem : 17'd0;
    crc_in = (st == CRC) ? {15'd0, crc_left} : 17'd2;
    p = (rem_in > avail) ? avail : rem_in;
    left = avail - p;
    c = (crc_in > left) ? left : crc_in;
    rem_nx = rem_in - p;
    crc_nx = crc_in - c;
    fin = long_go && rem_nx == 17'd0 && crc_nx == 17'd0;
    vc_ok = (st == IDLE) ? VC_MASK[hdr.vc] : vc_en;
    pay_go = long_go && p != 17'd0 && vc_ok;
    pl = data_i >> {hoff, 3'b000};
    pbe = BYTES'((17'd1 << p) - 17'd1);
    nxt = (!valid_i || st == DROP) ? st : (hdr_go && bad) ? DROP : (short_go || fin) ? IDLE :
          (rem_nx != 17'd0) ? PAYLOAD : CRC;
  end
`ifdef CSI2_PKT_CRC_EN
  logic [15:0] crc_q, crc_cur, crc_upd, rx_crc, rx_full;
  assign crc_cur = (st == IDLE) ? CRC_INIT : crc_q;
  csi2_crc16_bytes #(.BYTES(BYTES)) u_crc (.crc_in(crc_cur), .data(pl), .be(pbe), .crc(crc_upd));
  // Received CRC may straddle two words; merge bytes present now with those captured earlier.
  always_comb begin
    rx_full = rx_crc;
    for (int i = 0; i < 2; i++)
      if (i >= 2 - int'(crc_in) && i < 2 - int'(crc_in) + int'(c))
        rx_full[8*i +: 8] = 8'(data_i >> (8 * (int'(hoff) + int'(p) + i + int'(crc_in) - 2)));
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_q <= CRC_INIT;
      rx_crc <= '0;
    end else if (long_go) begin
      crc_q <= crc_upd;
      rx_crc <= rx_full;
    end
  end
`endif
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      rem <= '0;
      crc_left <= '0;
      vc_en <= 1'b0;
      short_pkt_valid_o <= 1'b0;
      short_pkt_v_channel_o <= '0;
      short_pkt_data_type_o <= '0;
      short_pkt_data_field_o <= '0;
      long_pkt_header_valid_o <= 1'b0;
      long_pkt_v_channel_o <= '0;
      long_pkt_data_type_o <= '0;
      long_pkt_word_cnt_o <= '0;
      long_pkt_payload_o <= '0;
      long_pkt_payload_valid_o <= 1'b0;
      long_pkt_payload_be_o <= '0;
      long_pkt_payload_last_o <= 1'b0;
      pkt_done_o <= 1'b0;
      hdr_err_o <= 1'b0;
      crc_err_o <= 1'b0;
    end else begin
      state <= nxt;
      if (long_go) begin
        rem <= rem_nx;
        crc_left <= 2'(crc_nx);
      end
      if (long_hdr) vc_en <= VC_MASK[hdr.vc];
      short_pkt_valid_o <= short_go && VC_MASK[hdr.vc];
      if (short_go) begin
        short_pkt_v_channel_o <= hdr.vc;
        short_pkt_data_type_o <= hdr.dt;
        short_pkt_data_field_o <= hdr.wc;
      end
      long_pkt_header_valid_o <= long_hdr && VC_MASK[hdr.vc];
      if (long_hdr) begin
        long_pkt_v_channel_o <= hdr.vc;
        long_pkt_data_type_o <= hdr.dt;
        long_pkt_word_cnt_o <= hdr.wc;
      end
      long_pkt_payload_o <= pl;
      long_pkt_payload_valid_o <= pay_go;
      long_pkt_payload_be_o <= pay_go ? pbe : '0;
      long_pkt_payload_last_o <= pay_go && rem_nx == 17'd0;
      pkt_done_o <= short_go || fin;
      hdr_err_o <= hdr_go && bad;
`ifdef CSI2_PKT_CRC_EN
      crc_err_o <= fin && crc_upd != rx_full;
`else
      crc_err_o <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_csi2_pkt_handler_mw.sv
// tb_csi2_pkt_handler_mw: directed checks on 32-bit, 64-bit and VC-filtered instances sharing one stimulus stream.
module tb_csi2_pkt_handler_mw;
`ifdef CSI2_PKT_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif
  logic clk = 1'b0, rst_n, sync, valid, err, errc;
  logic [63:0] data;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] crc;
  logic a_sv, a_hv, a_pv, a_last, a_done, a_herr, a_cerr;
  logic [1:0] a_svc, a_lvc;
  logic [5:0] a_sdt, a_ldt;
  logic [15:0] a_sdf, a_lwc;
  logic [31:0] a_pay;
  logic [3:0] a_be;
  logic b_sv, b_hv, b_pv, b_last, b_done, b_herr, b_cerr;
  logic [1:0] b_svc, b_lvc;
  logic [5:0] b_sdt, b_ldt;
  logic [15:0] b_sdf, b_lwc;
  logic [63:0] b_pay;
  logic [7:0] b_be;
  logic m_sv, m_hv, m_pv, m_last, m_done, m_herr, m_cerr;
  logic [1:0] m_svc, m_lvc;
  logic [5:0] m_sdt, m_ldt;
  logic [15:0] m_sdf, m_lwc;
  logic [31:0] m_pay;
  logic [3:0] m_be;
  always #5 clk = ~clk;
  csi2_pkt_handler_mw #(.DATA_W(32), .VC_MASK(4'hF)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .valid_i(valid), .data_i(data[31:0]),
    .error_i(err), .error_corrected_i(errc),
    .short_pkt_valid_o(a_sv), .short_pkt_v_channel_o(a_svc), .short_pkt_data_type_o(a_sdt),
    .short_pkt_data_field_o(a_sdf), .long_pkt_header_valid_o(a_hv), .long_pkt_v_channel_o(a_lvc),
    .long_pkt_data_type_o(a_ldt), .long_pkt_word_cnt_o(a_lwc), .long_pkt_payload_o(a_pay),
    .long_pkt_payload_valid_o(a_pv), .long_pkt_payload_be_o(a_be), .long_pkt_payload_last_o(a_last),
    .pkt_done_o(a_done), .hdr_err_o(a_herr), .crc_err_o(a_cerr));
  csi2_pkt_handler_mw #(.DATA_W(64), .VC_MASK(4'hF)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .valid_i(valid), .data_i(data),
    .error_i(err), .error_corrected_i(errc),
    .short_pkt_valid_o(b_sv), .short_pkt_v_channel_o(b_svc), .short_pkt_data_type_o(b_sdt),
    .short_pkt_data_field_o(b_sdf), .long_pkt_header_valid_o(b_hv), .long_pkt_v_channel_o(b_lvc),
    .long_pkt_data_type_o(b_ldt), .long_pkt_word_cnt_o(b_lwc), .long_pkt_payload_o(b_pay),
    .long_pkt_payload_valid_o(b_pv), .long_pkt_payload_be_o(b_be), .long_pkt_payload_last_o(b_last),
    .pkt_done_o(b_done), .hdr_err_o(b_herr), .crc_err_o(b_cerr));
  csi2_pkt_handler_mw #(.DATA_W(32), .VC_MASK(4'h1)) u_m (
    .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .valid_i(valid), .data_i(data[31:0]),
    .error_i(err), .error_corrected_i(errc),
    .short_pkt_valid_o(m_sv), .short_pkt_v_channel_o(m_svc), .short_pkt_data_type_o(m_sdt),
    .short_pkt_data_field_o(m_sdf), .long_pkt_header_valid_o(m_hv), .long_pkt_v_channel_o(m_lvc),
    .long_pkt_data_type_o(m_ldt), .long_pkt_word_cnt_o(m_lwc), .long_pkt_payload_o(m_pay),
    .long_pkt_payload_valid_o(m_pv), .long_pkt_payload_be_o(m_be), .long_pkt_payload_last_o(m_last),
    .pkt_done_o(m_done), .hdr_err_o(m_herr), .crc_err_o(m_cerr));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic v, input logic [63:0] d, input logic s = 1'b0,
                      input logic e = 1'b0, input logic ec = 1'b0);
    @(negedge clk);
    valid = v;
    data = d;
    sync = s;
    err = e;
    errc = ec;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  function automatic logic [15:0] crc16(input logic [63:0] d, input int n);
    logic [15:0] r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      r = r ^ {8'h00, d[8*i +: 8]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; sync = 1'b0; valid = 1'b0; err = 1'b0; errc = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_sv", a_sv, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_be", b_be, 0);
    chk("rst_a_sdf", a_sdf, 0);
    @(negedge clk) rst_n = 1'b1;
    // short packet, VC1 DT0 field 1234
    send(1, 64'h40123400);
    chk("t1_sv", a_sv, 1);
    chk("t1_vc", a_svc, 1);
    chk("t1_dt", a_sdt, 0);
    chk("t1_field", a_sdf, 16'h1234);
    chk("t1_done", a_done, 1);
    chk("t1_hv", a_hv, 0);
    chk("t1_pv", a_pv, 0);
    send(0, 0);
    chk("t1_sv_off", a_sv, 0);
    chk("t1_done_off", a_done, 0);
    // long DT 2A WC 6 on 32-bit with a gap cycle
    crc = crc16(64'h665544332211, 6);
    send(1, 64'h2A000600);
    chk("t2_hv", a_hv, 1);
    chk("t2_dt", a_ldt, 6'h2A);
    chk("t2_wc", a_lwc, 6);
    chk("t2_pv_hdr", a_pv, 0);
    send(1, 64'h44332211);
    chk("t2_pv1", a_pv, 1);
    chk("t2_be1", a_be, 4'hF);
    chk("t2_last1", a_last, 0);
    chk("t2_pay1", a_pay, 32'h44332211);
    chk("t2_hv_off", a_hv, 0);
    send(0, 0);
    chk("t2_gap_pv", a_pv, 0);
    chk("t2_gap_done", a_done, 0);
    send(1, {32'h0, crc, 16'h6655});
    chk("t2_pv2", a_pv, 1);
    chk("t2_be2", a_be, 4'h3);
    chk("t2_last2", a_last, 1);
    chk("t2_pay2", a_pay, {crc, 16'h6655});
    chk("t2_done", a_done, 1);
    chk("t2_crcerr", a_cerr, 0);
    send(0, 0);
    chk("t2_done_off", a_done, 0);
    // 64-bit long WC 8: header word carries payload bytes 0..3
    do_reset();
    crc = crc16(64'h0807060504030201, 8);
    send(1, 64'h04030201_24000800);
    chk("t3_hv", b_hv, 1);
    chk("t3_wc", b_lwc, 8);
    chk("t3_pv0", b_pv, 1);
    chk("t3_be0", b_be, 8'h0F);
    chk("t3_pay0", b_pay, 64'h04030201);
    chk("t3_last0", b_last, 0);
    chk("t3_done0", b_done, 0);
    send(1, {16'h0, crc, 32'h08070605});
    chk("t3_pv1", b_pv, 1);
    chk("t3_be1", b_be, 8'h0F);
    chk("t3_last1", b_last, 1);
    chk("t3_done", b_done, 1);
    chk("t3_crcerr", b_cerr, 0);
    // uncorrectable header error, drop until sync
    do_reset();
    send(1, 64'h40123400, 0, 1, 0);
    chk("t4_herr", a_herr, 1);
    chk("t4_sv", a_sv, 0);
    chk("t4_done", a_done, 0);
    send(1, 64'h00567800);
    chk("t4_drop_sv", a_sv, 0);
    chk("t4_drop_herr", a_herr, 0);
    send(0, 0, 1);
    send(1, 64'h00567800);
    chk("t4_sv_after", a_sv, 1);
    chk("t4_field", a_sdf, 16'h5678);
    chk("t4_vc", a_svc, 0);
    send(1, 64'h01ABCD00, 0, 1, 1);
    chk("t4_corr_sv", a_sv, 1);
    chk("t4_corr_dt", a_sdt, 6'h01);
    chk("t4_corr_herr", a_herr, 0);
    // VC2 long packet: filtered in the VC_MASK=1 instance, passed in the other
    do_reset();
    crc = crc16(64'hBBAA, 2);
    send(1, 64'hAA000200);
    chk("t5_m_hv", m_hv, 0);
    chk("t5_a_hv", a_hv, 1);
    chk("t5_a_vc", a_lvc, 2);
    send(1, {32'h0, crc, 16'hBBAA});
    chk("t5_m_pv", m_pv, 0);
    chk("t5_m_done", m_done, 1);
    chk("t5_a_pv", a_pv, 1);
    chk("t5_a_be", a_be, 4'h3);
    // sync aborts a long packet without pkt_done
    send(1, 64'h2A000600);
    send(1, 64'h44332211);
    send(0, 0, 1);
    chk("ab_done", a_done, 0);
    send(1, 64'h2A000600);
    chk("ab_hv", a_hv, 1);
    send(1, 64'h40123400, 1);
    chk("ab_same_sv", a_sv, 1);
    chk("ab_same_pv", a_pv, 0);
    // WC 4 with CRC in its own word: corrupted, then correct
    crc = crc16(64'h04030201, 4);
    send(1, 64'h2A000400);
    send(1, 64'h04030201);
    chk("t6_last", a_last, 1);
    chk("t6_done_early", a_done, 0);
    send(1, {48'h0, crc ^ 16'h0001});
    chk("t6_pv_crc", a_pv, 0);
    chk("t6_done_bad", a_done, 1);
    chk("t6_crcerr_bad", a_cerr, CRC_ON);
    send(1, 64'h2A000400);
    send(1, 64'h04030201);
    send(1, {48'h0, crc});
    chk("t6_done_ok", a_done, 1);
    chk("t6_crcerr_ok", a_cerr, 0);
    // reset in the middle of a packet
    send(1, 64'h2A000600);
    send(1, 64'h44332211);
    chk("mr_pv_before", a_pv, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_pv", a_pv, 0);
    chk("mr_be", a_be, 0);
    @(negedge clk) rst_n = 1'b1;
    send(1, 64'h40123400);
    chk("mr_sv", a_sv, 1);
    send(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
